// File: rtl/frame_scheduler.sv
// Frame sequencer: N ping/pong data beats, META_LEN metadata beats, then a tlast counter beat.
// Optional metadata stall timeout enabled by defining FRAME_SCHED_META_TIMEOUT_EN.
module frame_scheduler #(
    parameter int DW       = 128,
    parameter int META_LEN = 2,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic [15:0]         beats_per_frame,
    input  logic [DW-1:0]       s0_tdata,
    input  logic                s0_tvalid,
    output logic                s0_tready,
    input  logic [DW-1:0]       s1_tdata,
    input  logic                s1_tvalid,
    output logic                s1_tready,
    input  logic [DW-1:0]       meta_tdata,
    input  logic                meta_tvalid,
    output logic                meta_tready,
    output logic [DW-1:0]       m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [DW/8-1:0]     m_tkeep,
    output logic [CNT_W-1:0]    frame_count,
    output logic [2:0]          fsm_state,
    output logic                meta_timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        META  = 3'd2,
        COUNT = 3'd3
    } state_t;

    state_t      state;
    logic        ping_sel;
    logic [15:0] len_q;
    logic [15:0] beat_cnt;
    logic [15:0] len_next;
    logic        xfer;

`ifdef FRAME_SCHED_META_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic          to_mode;
    logic [TW-1:0] stall_cnt;
`endif

    assign len_next  = (beats_per_frame == 16'd0) ? 16'd1 : beats_per_frame;
    assign xfer      = m_tvalid & m_tready;
    assign m_tkeep   = {(DW/8){m_tvalid}};
    assign fsm_state = state;

    always_comb begin
        s0_tready   = 1'b0;
        s1_tready   = 1'b0;
        meta_tready = 1'b0;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        m_tdata     = '0;
        case (state)
            DATA: begin
                if (ping_sel) begin
                    m_tvalid  = s1_tvalid;
                    m_tdata   = s1_tdata;
                    s1_tready = m_tready;
                end else begin
                    m_tvalid  = s0_tvalid;
                    m_tdata   = s0_tdata;
                    s0_tready = m_tready;
                end
            end
            META: begin
`ifdef FRAME_SCHED_META_TIMEOUT_EN
                // After a timeout the remaining metadata beats are emitted as zeros.
                if (to_mode) begin
                    m_tvalid = 1'b1;
                end else
`endif
                begin
                    m_tvalid    = meta_tvalid;
                    m_tdata     = meta_tdata;
                    meta_tready = m_tready;
                end
            end
            COUNT: begin
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                m_tdata  = DW'(frame_count);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            ping_sel    <= 1'b0;
            frame_count <= '0;
            beat_cnt    <= '0;
            len_q       <= 16'd1;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    len_q    <= len_next;
                    beat_cnt <= '0;
                    state    <= DATA;
                end
                DATA: if (xfer) begin
                    if (beat_cnt == len_q - 16'd1) begin
                        beat_cnt <= '0;
                        state    <= META;
                    end else begin
                        beat_cnt <= beat_cnt + 16'd1;
                    end
                end
                // beat_cnt is reused to count metadata beats.
                META: if (xfer) begin
                    if (beat_cnt == 16'(META_LEN - 1)) begin
                        beat_cnt <= '0;
                        state    <= COUNT;
                    end else begin
                        beat_cnt <= beat_cnt + 16'd1;
                    end
                end
                COUNT: if (xfer) begin
                    frame_count <= frame_count + 1'b1;
                    ping_sel    <= ~ping_sel;
                    beat_cnt    <= '0;
                    if (enable) begin
                        len_q <= len_next;
                        state <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FRAME_SCHED_META_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            to_mode      <= 1'b0;
            stall_cnt    <= '0;
            meta_timeout <= 1'b0;
        end else if (state != META) begin
            to_mode   <= 1'b0;
            stall_cnt <= '0;
        end else if (!to_mode) begin
            if (meta_tvalid) begin
                stall_cnt <= '0;
            end else if (stall_cnt == TW'(TIMEOUT - 1)) begin
                to_mode      <= 1'b1;
                meta_timeout <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`else
    assign meta_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: vector table plus hand-written multi-cycle sequences.
module tb_frame_scheduler;
    localparam int DW = 32, ML = 2, CW = 4, TO = 10;
    localparam logic [31:0] S0 = 32'hA0A0_0001, S1 = 32'hB1B1_0002, MD = 32'hC2C2_0003;

    logic clk = 0, resetn = 0, enable = 0;
    logic [15:0] bpf = 16'd0;
    logic [DW-1:0] s0_tdata = S0, s1_tdata = S1, meta_tdata = MD, m_tdata;
    logic s0_tvalid = 0, s1_tvalid = 0, meta_tvalid = 0, m_tready = 0;
    logic s0_tready, s1_tready, meta_tready, m_tvalid, m_tlast, meta_timeout;
    logic [DW/8-1:0] m_tkeep;
    logic [CW-1:0] frame_count;
    logic [2:0] fsm_state;

    int n_chk = 0, n_fail = 0;

    frame_scheduler #(.DW(DW), .META_LEN(ML), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .beats_per_frame(bpf),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .meta_tdata(meta_tdata), .meta_tvalid(meta_tvalid), .meta_tready(meta_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tkeep(m_tkeep), .frame_count(frame_count), .fsm_state(fsm_state),
        .meta_timeout(meta_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [15:0] bpf;
        logic        s0v, s1v, mv, rdy;
        logic [2:0]  st;
        logic        v, l;
        logic [31:0] d;
        logic [2:0]  r;
        logic [3:0]  fc;
    } vec_t;

    vec_t tv[20];

    function automatic vec_t mk(input logic en, input logic [15:0] b, input logic s0v, s1v, mv, rdy,
                                input logic [2:0] st, input logic v, l, input logic [31:0] d,
                                input logic [2:0] r, input logic [3:0] fc);
        mk = '{en, b, s0v, s1v, mv, rdy, st, v, l, d, r, fc};
    endfunction

    // {state, valid, last, keep, data, {s0r,s1r,mr}, frame_count}
    function automatic logic [63:0] obs();
        obs = {16'd0, fsm_state, m_tvalid, m_tlast, m_tkeep, m_tdata,
               s0_tready, s1_tready, meta_tready, frame_count};
    endfunction

    function automatic logic [63:0] expd(input vec_t t);
        expd = {16'd0, t.st, t.v, t.l, (t.v ? 4'hF : 4'h0), t.d, t.r, t.fc};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        int n, nx, last_at, errs, stab, nb, stall, zb;
        logic prev_stall, prev_l;
        logic [31:0] prev_d, exp_d;
        logic [3:0] cb[17];

        tv[0] = mk(1, 4, 1, 1, 1, 1, 0, 0, 0, 0, 3'b000, 0);
        for (int i = 1; i <= 4; i++) tv[i] = mk(1, 4, 1, 1, 1, 1, 1, 1, 0, S0, 3'b100, 0);
        tv[5]  = mk(1, 4, 1, 1, 1, 1, 2, 1, 0, MD, 3'b001, 0);
        tv[6]  = tv[5];
        tv[7]  = mk(1, 4, 1, 1, 1, 1, 3, 1, 1, 32'd0, 3'b000, 0);
        tv[8]  = mk(1, 4, 1, 1, 1, 1, 1, 1, 0, S1, 3'b010, 1);
        for (int i = 9; i <= 11; i++) tv[i] = mk(1, 0, 1, 1, 1, 1, 1, 1, 0, S1, 3'b010, 1);
        tv[12] = mk(1, 0, 1, 1, 1, 1, 2, 1, 0, MD, 3'b001, 1);
        tv[13] = tv[12];
        tv[14] = mk(1, 0, 1, 1, 1, 1, 3, 1, 1, 32'd1, 3'b000, 1);
        tv[15] = mk(1, 8, 1, 1, 1, 1, 1, 1, 0, S0, 3'b100, 2);
        tv[16] = mk(0, 8, 1, 1, 0, 1, 2, 0, 0, MD, 3'b001, 2);
        tv[17] = mk(0, 8, 1, 1, 1, 1, 2, 1, 0, MD, 3'b001, 2);
        tv[18] = tv[17];
        tv[19] = mk(1, 8, 1, 1, 1, 1, 3, 1, 1, 32'd2, 3'b000, 2);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset", obs(), expd(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0)));
        check("reset_timeout", {63'd0, meta_timeout}, 64'd0);

        // Table: basic frame, pong frame, length 0, mid-frame length change, enable drop
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            resetn = 1; enable = tv[i].en; bpf = tv[i].bpf;
            s0_tvalid = tv[i].s0v; s1_tvalid = tv[i].s1v; meta_tvalid = tv[i].mv; m_tready = tv[i].rdy;
            #1;
            check($sformatf("vec%0d", i), obs(), expd(tv[i]));
        end

        // 8-beat frame from pong (latched at tv[19]); enable dropped mid-frame
        n = 0; errs = 0; exp_d = 32'hFFFF_FFFF;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); enable = 0; bpf = 16'd2; #1;
            if (m_tvalid && m_tready) begin
                n++;
                if (n <= 8 && m_tdata !== S1) errs++;
                if (n > 8 && n <= 10 && m_tdata !== MD) errs++;
                if (m_tlast) begin exp_d = m_tdata; break; end
            end
        end
        check("len8_beats", 64'(n), 64'd11);
        check("len8_data", 64'(errs), 64'd0);
        check("len8_cntbeat", 64'(exp_d), 64'd3);
        @(negedge clk); #1;
        check("len8_idle", {56'd0, 1'b0, fsm_state, frame_count}, {56'd0, 1'b0, 3'd0, 4'd4});

        // Backpressure: tready toggles, source data advances per transfer
        @(negedge clk); enable = 1; bpf = 16'd4; m_tready = 0;
        nx = 0; last_at = 0; errs = 0; stab = 0; prev_stall = 0; prev_d = 0; prev_l = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            enable = 0; m_tready = c[0]; s0_tdata = 32'hD000_0000 + 32'(nx);
            #1;
            if (m_tvalid) begin
                if (prev_stall && (m_tdata !== prev_d || m_tlast !== prev_l)) stab++;
                if (m_tready) begin
                    exp_d = (nx < 4) ? 32'hD000_0000 + 32'(nx) : (nx < 6) ? MD : 32'd4;
                    if (m_tdata !== exp_d || m_tlast !== (nx == 6)) errs++;
                    nx++; prev_stall = 0;
                    if (m_tlast) begin last_at = nx; break; end
                end else begin
                    prev_stall = 1; prev_d = m_tdata; prev_l = m_tlast;
                end
            end else prev_stall = 0;
        end
        s0_tdata = S0;
        check("bp_xfers", 64'(nx), 64'd7);
        check("bp_tlast_at", 64'(last_at), 64'd7);
        check("bp_data", 64'(errs), 64'd0);
        check("bp_stable", 64'(stab), 64'd0);
        @(negedge clk); m_tready = 1; #1;
        check("bp_idle", {57'd0, fsm_state, frame_count}, {57'd0, 3'd0, 4'd5});

        // Reset in the middle of META
        enable = 1; bpf = 16'd1;
        @(negedge clk); enable = 0;
        @(negedge clk); #1;
        check("pre_reset_meta", {61'd0, fsm_state}, 64'd2);
        resetn = 0;
        @(negedge clk); #1;
        check("mid_reset", obs(), expd(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0)));

        // Counter wrap with CNT_W=4
        resetn = 1; enable = 1; bpf = 16'd1; nb = 0;
        for (int c = 0; c < 200 && nb < 17; c++) begin
            @(negedge clk); #1;
            if (m_tvalid && m_tready && m_tlast) begin cb[nb] = m_tdata[3:0]; nb++; end
        end
        check("wrap_frames", 64'(nb), 64'd17);
        if (nb == 17) begin
            check("wrap_first", 64'(cb[0]), 64'd0);
            check("wrap_15", 64'(cb[15]), 64'd15);
            check("wrap_0", 64'(cb[16]), 64'd0);
        end

`ifdef FRAME_SCHED_META_TIMEOUT_EN
        @(negedge clk); resetn = 0;
        @(negedge clk); resetn = 1; enable = 1; bpf = 16'd1; meta_tvalid = 0;
        stall = 0; zb = 0; errs = 0; n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); enable = 0; #1;
            if (fsm_state == 3'd2 && !m_tvalid) stall++;
            if (fsm_state == 3'd2 && m_tvalid && m_tready) begin
                zb++;
                if (m_tdata !== 32'd0 || meta_tready !== 1'b0) errs++;
            end
            if (m_tvalid && m_tready && m_tlast) begin n = 1; break; end
        end
        check("to_done", 64'(n), 64'd1);
        check("to_stall", 64'(stall), 64'd10);
        check("to_zero_beats", 64'(zb), 64'd2);
        check("to_zero_data", 64'(errs), 64'd0);
        check("to_flag", {63'd0, meta_timeout}, 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check("to_sticky", {60'd0, fsm_state, meta_timeout}, {60'd0, 3'd0, 1'b1});
`else
        check("no_timeout_flag", {63'd0, meta_timeout}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Sequences the output AXI-stream into complete frames: N data beats from the active ping/pong source, then META_LEN metadata beats, then one frame-counter beat carrying tlast. It sits between the ping/pong frame buffers, the metadata source and the downstream packetiser/DMA. Unlike a free-running header inserter, it honours downstream backpressure on every beat, alternates ping and pong per frame, and maintains its own frame counter.

## Interface
Parameters:
- DW, 128, stream data width in bits (multiple of 8).
- META_LEN, 2, metadata beats per frame (≥1).
- CNT_W, 32, frame counter width (≤DW).
- TIMEOUT, 255, metadata stall limit in cycles (used only with the macro).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- enable  in  1  start frames; sampled only in IDLE and at the end of a frame.
- beats_per_frame  in  16  data beats per frame; latched at frame start; 0 is treated as 1.
- s0_tdata / s0_tvalid / s0_tready  in/in/out  DW/1/1  ping source.
- s1_tdata / s1_tvalid / s1_tready  in/in/out  DW/1/1  pong source.
- meta_tdata / meta_tvalid / meta_tready  in/in/out  DW/1/1  metadata source.
- m_tdata / m_tvalid / m_tready  out/out/in  DW/1/1  output stream.
- m_tlast  out  1  high on the frame-counter beat only.
- m_tkeep  out  DW/8  all ones when m_tvalid is high, otherwise 0.
- frame_count  out  CNT_W  completed frames.
- fsm_state  out  3  current state encoding.
- meta_timeout  out  1  sticky flag, set when metadata timed out; cleared by reset.

## Operation
- States: IDLE=0, DATA=1, META=2, COUNT=3. All other encodings return to IDLE.
- **IDLE**
  - All tready and m_tvalid are 0.
  - When enable=1: latch beats_per_frame into len_q (0 becomes 1), clear beat_cnt, go to DATA.
- **DATA**
  - The selected source is s0 when ping_sel=0, s1 when ping_sel=1.
  - m_tdata/m_tvalid pass through combinationally from the selected source; its tready = m_tready. The unselected source tready is 0.
  - Each transfer (valid & ready) increments beat_cnt.
  - The transfer with beat_cnt==len_q-1 moves to META and clears beat_cnt.
- **META**
  - meta stream passes through the same way; the s0/s1 tready are 0.
  - The META_LEN-th transfer moves to COUNT.
- **COUNT**
  - m_tdata = frame_count zero-extended to DW; m_tvalid=1; m_tlast=1.
  - On transfer: frame_count+1 (wraps from 2^CNT_W-1 to 0), ping_sel toggles.
  - Next state is DATA with a fresh len_q latch if enable=1, otherwise IDLE.
- Deasserting enable mid-frame has no effect; the frame always completes.
- beats_per_frame changes mid-frame are ignored until the next latch.
- Reset values: state IDLE, ping_sel 0, frame_count 0, beat_cnt 0, meta_timeout 0. This gives m_tvalid 0, m_tlast 0, m_tkeep 0 and all tready 0.
- Reset mid-frame abandons the frame with no tlast and does not increment frame_count.

## Timing
- Zero-cycle latency on data and metadata beats (combinational pass-through).
- The COUNT beat is presented the cycle after the last metadata transfer.
- m_tvalid never depends on m_tready.
- While m_tvalid=1 and m_tready=0, m_tdata and m_tlast stay stable, since the state does not change without a transfer.
- Minimum frame length is len_q+META_LEN+1 cycles. There are no bubbles between back-to-back frames when enable stays high.
- The state register, counters and flags update only on the rising clk edge.

## Configuration
- Macro: FRAME_SCHED_META_TIMEOUT_EN.
- **Defined:** in META, a stall counter counts consecutive cycles with meta_tvalid=0 and is cleared on any meta transfer.
  - When it reaches TIMEOUT, the block stops accepting metadata (meta_tready=0) and emits each remaining metadata beat as DW'b0 with m_tvalid=1, still honouring m_tready.
  - It sets meta_timeout, then proceeds to COUNT.
- **Not defined:** META waits indefinitely for metadata; meta_timeout is tied to 0.

## Test plan
- **Basic frame:** enable=1, beats_per_frame=4, META_LEN=2, all sources valid, m_tready=1.
  - Output: 4 s0 beats, 2 meta beats, then one beat of data 0 with tlast.
  - frame_count becomes 1; the next frame takes 4 beats from s1.
- **Backpressure:** m_tready toggles 1/0 every cycle during a frame.
  - Output beats are unchanged and stable while stalled.
  - Exactly 7 transfers occur; tlast appears only on the 7th.
- **Length 0 and mid-frame change:** beats_per_frame=0 sends 1 data beat.
  - Changing beats_per_frame to 8 mid-frame affects only the next frame.
- **Enable drop and reset:** enable drops during DATA and the frame completes, then the block goes to IDLE.
  - Asserting resetn=0 mid-META gives state 0, m_tvalid=0 and frame_count=0 on the next edge.
- **Counter wrap:** with CNT_W=4, after 16 frames the counter beat reads 15, then 0.
- **Timeout (macro on):** TIMEOUT=10, meta_tvalid held 0 in META.
  - After 10 cycles, 2 zero beats are emitted, then the counter beat; meta_timeout=1 and stays sticky.
